// File: rtl/stage3_arb_pkg.sv
// -----------------------------------------------------------------------------
// stage3_arb_pkg
// Shared types for the stage-3 memory arbiter.
//   arb_state_t : arbiter ownership state (IDLE / FETCH / DATA)
//   arb_req_t   : one latched bus request (address, store data, byte enables,
//                 read strobe, write strobe)
// The struct is sized by ARB_ADDR_W / ARB_DATA_W. The top level's ADDR_W and
// DATA_W parameters default to these values and must be kept equal to them.
// -----------------------------------------------------------------------------
package stage3_arb_pkg;

   localparam int ARB_ADDR_W = 32;
   localparam int ARB_DATA_W = 32;
   localparam int ARB_BE_W   = ARB_DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] wdata;
      logic [ARB_BE_W-1:0]   byte_en;
      logic                  ren;
      logic                  wen;
   } arb_req_t;

endpackage

// File: rtl/stage3_arb_req_latch.sv
// -----------------------------------------------------------------------------
// stage3_arb_req_latch
// Holds the request currently presented on the memory bus.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous reset, active-high; clears the held request
//   load  in   capture d (takes priority over clear)
//   clear in   drop the held request, which deasserts the bus strobes
//   d     in   request to capture
//   q     out  held request driving the bus
// -----------------------------------------------------------------------------
module stage3_arb_req_latch
   import stage3_arb_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     load,
   input  logic     clear,
   input  arb_req_t d,
   output arb_req_t q
);

   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (clear) begin
         q <= '0;
      end
   end

endmodule

// File: rtl/stage3_mem_arbiter.sv
// -----------------------------------------------------------------------------
// stage3_mem_arbiter
// Shares one memory bus between the stage-3 fetch port and data port. One
// requester owns the bus at a time; its latched request is held until the bus
// reports completion (bus_busy==0). Data wins a simultaneous request, and the
// requester that just completed is never re-granted directly, so contention
// alternates D,I,D,I. Completion hands over to the other requester with no
// idle cycle.
//
// Optional feature (macro STAGE3_ARB_FETCH_ABORT_EN):
//   i_abort during a fetch (grant cycle, in flight or completion cycle) drops
//   that fetch's result: i_busy stays high. Without the macro i_abort is ignored
//   and every completed fetch is delivered.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   iren, suppress_iren      fetch request and its hazard-unit veto
//   i_abort                  fetch redirect (used only with the macro)
//   iaddr                    fetch address
//   i_rdata, i_busy          fetch result; i_busy low for the completion cycle
//   dren, dwen               data read / write request (mutually exclusive)
//   suppress_data            hazard-unit veto for the data request
//   daddr, dwdata, dbyte_en  data address, store data, store byte enables
//   d_rdata, d_busy          data result; d_busy low for the completion cycle
//   bus_addr, bus_wdata,
//   bus_byte_en              latched request fields (byte_en all-ones on reads)
//   bus_ren, bus_wen         registered strobes, high for the whole transaction
//   bus_rdata, bus_busy      bus read data; bus_busy==0 means done this cycle
// -----------------------------------------------------------------------------
module stage3_mem_arbiter
   import stage3_arb_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int DATA_W = ARB_DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                iren,
   input  logic                suppress_iren,
   input  logic                i_abort,
   input  logic [ADDR_W-1:0]   iaddr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_busy,
   input  logic                dren,
   input  logic                dwen,
   input  logic                suppress_data,
   input  logic [ADDR_W-1:0]   daddr,
   input  logic [DATA_W-1:0]   dwdata,
   input  logic [DATA_W/8-1:0] dbyte_en,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_busy,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   output logic [DATA_W/8-1:0] bus_byte_en,
   output logic                bus_ren,
   output logic                bus_wen,
   input  logic [DATA_W-1:0]   bus_rdata,
   input  logic                bus_busy
);

   arb_state_t state;
   arb_req_t   fetch_req;
   arb_req_t   data_req;
   arb_req_t   load_req;
   arb_req_t   cur_req;

   logic ireq;
   logic dreq;
   logic done;
   logic grant_i;
   logic grant_d;
   logic load;
   logic clear;
   logic drop_now;

   assign ireq = iren & ~suppress_iren;
   assign dreq = (dren | dwen) & ~suppress_data;
   assign done = (state != IDLE) & ~bus_busy;

   // Candidate requests as they would be latched on a grant.
   always_comb begin
      fetch_req         = '0;
      fetch_req.addr    = iaddr;
      fetch_req.byte_en = '1;
      fetch_req.ren     = 1'b1;

      data_req          = '0;
      data_req.addr     = daddr;
      data_req.wdata    = dwen ? dwdata : '0;
      data_req.byte_en  = dwen ? dbyte_en : '1;
      data_req.ren      = dren;
      data_req.wen      = dwen;
   end

   // Grant decision. A completing owner may only hand over to the other side,
   // which is what guarantees alternation under contention.
   // NOTE: every signal written here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      unique case (state)
         IDLE: begin
            if (dreq)      grant_d = 1'b1;
            else if (ireq) grant_i = 1'b1;
         end
         FETCH:   grant_d = done & dreq;
         DATA:    grant_i = done & ireq;
         default: ;
      endcase
   end

   assign load     = grant_i | grant_d;
   assign clear    = done & ~load;
   assign load_req = grant_d ? data_req : fetch_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else if (grant_d) begin
         state <= DATA;
      end else if (grant_i) begin
         state <= FETCH;
      end else if (done) begin
         state <= IDLE;
      end
   end

   stage3_arb_req_latch u_req_latch (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .clear (clear),
      .d     (load_req),
      .q     (cur_req)
   );

`ifdef STAGE3_ARB_FETCH_ABORT_EN
   logic drop;

   // Remembers a redirect seen while the fetch was granted or in flight; a
   // redirect in the completion cycle itself is caught by drop_now directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop <= 1'b0;
      end else if ((state == FETCH) && done) begin
         drop <= 1'b0;
      end else if (i_abort && ((state == FETCH) || grant_i)) begin
         drop <= 1'b1;
      end
   end

   assign drop_now = drop | i_abort;
`else
   logic unused_abort;
   assign unused_abort = i_abort;
   assign drop_now     = 1'b0;
`endif

   assign i_busy  = ~((state == FETCH) & done & ~drop_now);
   assign d_busy  = ~((state == DATA) & done);
   assign i_rdata = (state == FETCH) ? bus_rdata : '0;
   assign d_rdata = (state == DATA)  ? bus_rdata : '0;

   assign bus_addr    = cur_req.addr;
   assign bus_wdata   = cur_req.wdata;
   assign bus_byte_en = cur_req.byte_en;
   assign bus_ren     = cur_req.ren;
   assign bus_wen     = cur_req.wen;

   a_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(dren && dwen));

endmodule

// File: tb/tb_stage3_mem_arbiter.sv
module tb_stage3_mem_arbiter;
   import stage3_arb_pkg::*;

`ifdef STAGE3_ARB_FETCH_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        iren, suppress_iren, i_abort;
   logic [31:0] iaddr;
   logic [31:0] i_rdata;
   logic        i_busy;
   logic        dren, dwen, suppress_data;
   logic [31:0] daddr, dwdata;
   logic [3:0]  dbyte_en;
   logic [31:0] d_rdata;
   logic        d_busy;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_byte_en;
   logic        bus_ren, bus_wen;
   logic [31:0] bus_rdata;
   logic        bus_busy;

   stage3_mem_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .iren          (iren),
      .suppress_iren (suppress_iren),
      .i_abort       (i_abort),
      .iaddr         (iaddr),
      .i_rdata       (i_rdata),
      .i_busy        (i_busy),
      .dren          (dren),
      .dwen          (dwen),
      .suppress_data (suppress_data),
      .daddr         (daddr),
      .dwdata        (dwdata),
      .dbyte_en      (dbyte_en),
      .d_rdata       (d_rdata),
      .d_busy        (d_busy),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_byte_en   (bus_byte_en),
      .bus_ren       (bus_ren),
      .bus_wen       (bus_wen),
      .bus_rdata     (bus_rdata),
      .bus_busy      (bus_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: who owns the bus and what request it presented.
   // owner 0 = nobody, 1 = fetch, 2 = data.
   // ---------------------------------------------------------------------------
   int          m_owner;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_be;
   logic        m_ren, m_wen, m_drop;

   task automatic model_reset();
      m_owner = 0;
      m_addr  = '0;
      m_wdata = '0;
      m_be    = '0;
      m_ren   = 1'b0;
      m_wen   = 1'b0;
      m_drop  = 1'b0;
   endtask

   // Called at the falling edge: compare this cycle's outputs, then advance.
   task automatic model_cycle();
      bit done, free, ie, de, e_ib, e_db;
      int nxt;
      done = (m_owner != 0) && !bus_busy;
      e_ib = !((m_owner == 1) && done && !(ABORT_EN && (m_drop || i_abort)));
      e_db = !((m_owner == 2) && done);

      check("m_bus_ren", bus_ren, m_ren);
      check("m_bus_wen", bus_wen, m_wen);
      check("m_bus_addr", bus_addr, m_addr);
      check("m_bus_be", bus_byte_en, m_be);
      check("m_bus_wdata", bus_wdata, m_wdata);
      check("m_i_busy", i_busy, e_ib);
      check("m_d_busy", d_busy, e_db);
      if (!e_ib) check("m_i_rdata", i_rdata, bus_rdata);
      if (!e_db) check("m_d_rdata", d_rdata, bus_rdata);

      ie   = iren && !suppress_iren;
      de   = (dren || dwen) && !suppress_data;
      free = (m_owner == 0) || done;
      nxt  = m_owner;
      if (free) begin
         // Data preferred; whoever just finished sits this slot out.
         if (de && m_owner != 2)      nxt = 2;
         else if (ie && m_owner != 1) nxt = 1;
         else                         nxt = 0;
      end

      if (ABORT_EN) begin
         if (m_owner == 1 && done) m_drop = 1'b0;
         else if (i_abort && (m_owner == 1 || (free && nxt == 1))) m_drop = 1'b1;
      end

      if (free) begin
         case (nxt)
            2: begin
               m_addr = daddr;  m_wdata = dwen ? dwdata : 32'h0;
               m_be = dwen ? dbyte_en : 4'hF; m_ren = dren; m_wen = dwen;
            end
            1: begin
               m_addr = iaddr; m_wdata = 32'h0; m_be = 4'hF; m_ren = 1'b1; m_wen = 1'b0;
            end
            default: begin
               m_addr = 32'h0; m_wdata = 32'h0; m_be = 4'h0; m_ren = 1'b0; m_wen = 1'b0;
            end
         endcase
      end
      m_owner = nxt;
   endtask

   // Inputs are driven at posedge+1; step compares at negedge and returns at
   // the next posedge+1.
   task automatic step();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      iren = 0; suppress_iren = 0; i_abort = 0; iaddr = '0;
      dren = 0; dwen = 0; suppress_data = 0; daddr = '0; dwdata = '0; dbyte_en = '0;
      bus_busy = 1'b1; bus_rdata = '0;
   endtask

   // ---------------------------------------------------------------------------
   // Vector table: lone fetch, then simultaneous fetch + store.
   // ---------------------------------------------------------------------------
   typedef struct {
      logic        iren;
      logic [31:0] iaddr;
      logic        dren, dwen;
      logic [31:0] daddr, dwdata;
      logic [3:0]  dbe;
      logic        bbusy;
      logic        e_ib, e_db, e_ren, e_wen;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_be;
   } vec_t;

   vec_t vecs[9];

   function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                               logic [31:0] dwd, logic [3:0] be, logic bb, logic eib, logic edb,
                               logic eren, logic ewen, logic [31:0] eaddr, logic [31:0] ewd,
                               logic [3:0] ebe);
      vec_t v;
      v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw; v.daddr = da; v.dwdata = dwd;
      v.dbe = be; v.bbusy = bb; v.e_ib = eib; v.e_db = edb; v.e_ren = eren; v.e_wen = ewen;
      v.e_addr = eaddr; v.e_wdata = ewd; v.e_be = ebe;
      return v;
   endfunction

   int cnt;
   int grants[8];
   int g;

   initial begin
      //            iren iaddr    dr dw daddr     dwdata        be    bb ib db rn wn addr      wdata         be
      vecs[0] = mk(1, 32'h100, 0, 0, 32'h0,    32'h0,        4'h0, 1, 1, 1, 0, 0, 32'h0,    32'h0,        4'h0);
      vecs[1] = mk(0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0, 1, 1, 1, 1, 0, 32'h100,  32'h0,        4'hF);
      vecs[2] = mk(0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0, 1, 1, 1, 1, 0, 32'h100,  32'h0,        4'hF);
      vecs[3] = mk(0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 1, 1, 0, 32'h100,  32'h0,        4'hF);
      vecs[4] = mk(0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0, 1, 1, 1, 0, 0, 32'h0,    32'h0,        4'h0);
      vecs[5] = mk(1, 32'h200, 0, 1, 32'h8000, 32'hDEADBEEF, 4'h3, 1, 1, 1, 0, 0, 32'h0,    32'h0,        4'h0);
      vecs[6] = mk(1, 32'h200, 0, 0, 32'h0,    32'h0,        4'h0, 0, 1, 0, 0, 1, 32'h8000, 32'hDEADBEEF, 4'h3);
      vecs[7] = mk(0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 1, 1, 0, 32'h200,  32'h0,        4'hF);
      vecs[8] = mk(0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0, 1, 1, 1, 0, 0, 32'h0,    32'h0,        4'h0);

      // ---- reset state ----
      idle_inputs();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_bus_ren", bus_ren, 1'b0);
      check("rst_bus_wen", bus_wen, 1'b0);
      check("rst_bus_addr", bus_addr, 32'h0);
      check("rst_bus_be", bus_byte_en, 4'h0);
      check("rst_i_busy", i_busy, 1'b1);
      check("rst_d_busy", d_busy, 1'b1);
      rst = 1'b0;

      // ---- table-driven sequence ----
      for (int i = 0; i < 9; i++) begin
         iren = vecs[i].iren; iaddr = vecs[i].iaddr;
         dren = vecs[i].dren; dwen = vecs[i].dwen; daddr = vecs[i].daddr;
         dwdata = vecs[i].dwdata; dbyte_en = vecs[i].dbe;
         bus_busy = vecs[i].bbusy; bus_rdata = 32'hA500_0000 | i;
         #2;
         check($sformatf("vec%0d_i_busy", i), i_busy, vecs[i].e_ib);
         check($sformatf("vec%0d_d_busy", i), d_busy, vecs[i].e_db);
         check($sformatf("vec%0d_ren", i), bus_ren, vecs[i].e_ren);
         check($sformatf("vec%0d_wen", i), bus_wen, vecs[i].e_wen);
         check($sformatf("vec%0d_addr", i), bus_addr, vecs[i].e_addr);
         check($sformatf("vec%0d_wdata", i), bus_wdata, vecs[i].e_wdata);
         check($sformatf("vec%0d_be", i), bus_byte_en, vecs[i].e_be);
         if (!vecs[i].e_ib) check($sformatf("vec%0d_i_rdata", i), i_rdata, 32'hA500_0000 | i);
         if (!vecs[i].e_db) check($sformatf("vec%0d_d_rdata", i), d_rdata, 32'hA500_0000 | i);
         step();
      end

      // ---- continuous contention, 1-cycle bus: D,I,D,I ----
      idle_inputs();
      iren = 1; iaddr = 32'h400; dren = 1; daddr = 32'h900; bus_busy = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         #3;
         g = 0;
         if (bus_ren && bus_addr == 32'h900) g = 2;
         else if (bus_ren && bus_addr == 32'h400) g = 1;
         grants[k] = g;
         check($sformatf("alt_grant%0d", k), g, (k % 2 == 0) ? 2 : 1);
         if (k > 0) check($sformatf("alt_nodup%0d", k), (grants[k] == grants[k-1]), 1'b0);
      end
      iren = 0; dren = 0;
      repeat (2) step();

      // ---- suppress_data gates grant, but not an issued transaction ----
      idle_inputs();
      dren = 1; daddr = 32'hA00; suppress_data = 1;
      for (int k = 0; k < 3; k++) begin
         step();
         #3;
         check($sformatf("supp_strobes%0d", k), {bus_ren, bus_wen}, 2'b00);
      end
      suppress_data = 0;
      step();
      suppress_data = 1; dren = 0;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         bus_busy = (k == 1) ? 1'b0 : 1'b1;
         bus_rdata = 32'h5A5A_0000 | k;
         #3;
         if (!d_busy) cnt++;
         step();
      end
      check("supp_mid_dbusy_lows", cnt, 1);
      suppress_data = 0;

      // ---- fetch abort mid-flight ----
      idle_inputs();
      iren = 1; iaddr = 32'h280;
      step();
      iren = 0;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         bus_busy = (k == 3) ? 1'b0 : 1'b1;
         i_abort  = (k == 1);
         bus_rdata = 32'h0BAD_0000 | k;
         #3;
         if (!i_busy) cnt++;
         step();
      end
      check("abort_mid_ibusy_lows", cnt, ABORT_EN ? 0 : 1);
      i_abort = 0;
      iren = 1; iaddr = 32'h300;
      step();
      iren = 0;
      check("redir_bus_addr", bus_addr, 32'h300);
      bus_busy = 1'b0; bus_rdata = 32'h3333_3333;
      #3;
      check("redir_i_busy", i_busy, 1'b0);
      check("redir_i_rdata", i_rdata, 32'h3333_3333);
      step();
      bus_busy = 1'b1;

      // abort coincident with the completion cycle
      iren = 1; iaddr = 32'h380;
      step();
      iren = 0;
      step();
      bus_busy = 1'b0; i_abort = 1'b1;
      #3;
      check("abort_at_done_i_busy", i_busy, ABORT_EN ? 1'b1 : 1'b0);
      step();
      i_abort = 0; bus_busy = 1'b1;
      step();

      // ---- asynchronous reset in the middle of a store ----
      idle_inputs();
      dwen = 1; daddr = 32'hB00; dwdata = 32'h1234_5678; dbyte_en = 4'hF;
      step();
      dwen = 0;
      step();
      check("pre_rst_wen", bus_wen, 1'b1);
      rst = 1'b1;
      #1;
      check("async_rst_wen", bus_wen, 1'b0);
      check("async_rst_addr", bus_addr, 32'h0);
      check("async_rst_i_busy", i_busy, 1'b1);
      check("async_rst_d_busy", d_busy, 1'b1);
      check("async_rst_state", dut.state, IDLE);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      dren = 1; daddr = 32'hC00; bus_busy = 1'b0; bus_rdata = 32'hC0C0_C0C0;
      step();
      dren = 0;
      check("post_rst_grant_addr", bus_addr, 32'hC00);
      #3;
      check("post_rst_d_busy", d_busy, 1'b0);
      step();

      // ---- randomized traffic against the model ----
      for (int n = 0; n < 3000; n++) begin
         int dsel;
         iren = 1'($urandom_range(0, 1));
         suppress_iren = ($urandom_range(0, 3) == 0);
         iaddr = $urandom;
         dsel = $urandom_range(0, 2);
         dren = (dsel == 1);
         dwen = (dsel == 2);
         suppress_data = ($urandom_range(0, 3) == 0);
         daddr = $urandom;
         dwdata = $urandom;
         dbyte_en = 4'($urandom_range(0, 15));
         i_abort = ($urandom_range(0, 7) == 0);
         bus_busy = 1'($urandom_range(0, 1));
         bus_rdata = $urandom;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
